wb_cmd_master: RTL and testbench

//  Wishbone B4 classic initiator for the user area: the requesting end of the

---
 rtl/wb_cmd_master.sv | 117 +++++++++++
 tb/tb_wb_cmd_master.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-beat initiator: one valid/ready command in, one bus
// cycle out, one valid/ready response back; stalled slaves are cut off and counted.
module wb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TOCNT_W = 16,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADDR_W-1:0]  cmd_adr_i,
    input  logic [DATA_W-1:0]  cmd_dat_i,
    input  logic [SEL_W-1:0]   cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATA_W-1:0]  rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [SEL_W-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]  wbm_adr_o,
    output logic [DATA_W-1:0]  wbm_dat_o,
    input  logic [DATA_W-1:0]  wbm_dat_i,
    input  logic               wbm_ack_i,
    output logic [TOCNT_W-1:0] to_cnt_o
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t             r_state, w_next;
    logic               r_cyc, r_we, r_rsp_valid, r_rsp_err;
    logic [SEL_W-1:0]   r_sel;
    logic [ADDR_W-1:0]  r_adr;
    logic [DATA_W-1:0]  r_dat, r_rsp_dat;
    logic [CNT_W-1:0]   r_cnt;
    logic [TOCNT_W-1:0] r_tocnt;
    logic               w_accept, w_timeout;

    assign w_accept  = cmd_valid_i && (r_state == S_IDLE);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)              w_next = S_BUS;
            S_BUS:   if (wbm_ack_i || w_timeout) w_next = S_RESP;
            S_RESP:  if (rsp_ready_i)            w_next = S_IDLE;
            default:                             w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_tocnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cyc <= 1'b1;
                    r_we  <= cmd_we_i;
                    r_sel <= cmd_sel_i;
                    r_adr <= cmd_adr_i;
                    r_dat <= cmd_dat_i;
                    r_cnt <= '0;
                end
                // Ack is checked first so a response on the last allowed cycle wins.
                S_BUS: if (wbm_ack_i) begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
                    r_rsp_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_dat   <= '0;
                    r_rsp_err   <= 1'b1;
                    if (r_tocnt != '1) r_tocnt <= r_tocnt + TOCNT_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_RESP: if (rsp_ready_i) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign to_cnt_o    = r_tocnt;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: the bench plays command source, WB slave
// and response sink, and predicts each transaction from its ack delay.
module tb_wb_cmd_master;
    localparam int TO = 4;
    localparam int TW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, sdat = '0;
    logic        ack = 1'b0;
    logic [TW-1:0] to_cnt;

    int n_vec = 0, n_err = 0;
    int m_to = 0;

    wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .TOCNT_W(TW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
        .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(sdat), .wbm_ack_i(ack),
        .to_cnt_o(to_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction. ack_dly = stb cycles before ack (>= TO means never ack),
    // stall = cycles the response is held off (with a stray command and ack offered).
    task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                       input logic [3:0] t_sel, input logic [31:0] rdata,
                       input int ack_dly, input int stall);
        int n;
        int exp_stb;
        logic exp_err;
        logic [31:0] exp_dat;
        exp_err = (ack_dly >= TO);
        exp_stb = exp_err ? TO : ack_dly + 1;
        exp_dat = (!t_we && !exp_err) ? rdata : 32'h0;
        if (exp_err && m_to < (1 << TW) - 1) m_to++;

        chk("ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr = $urandom; cmd_dat = $urandom;
        chk("ready_bus", {31'b0, cmd_ready}, 32'd0);
        n = 0;
        while (stb && n < TO + 3) begin
            n++;
            chk("cyc", {31'b0, cyc}, 32'd1);
            chk("adr", adr, t_adr);
            chk("attr", {wdat[27:0], sel}, {t_dat[27:0], t_sel});
            chk("we", {31'b0, we}, {31'b0, t_we});
            ack  = (n == ack_dly + 1);
            sdat = ack ? rdata : $urandom;
            @(negedge clk);
            ack = 1'b0;
            sdat = $urandom;
        end
        chk("stb_cycles", n, exp_stb);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        chk("to_cnt", {30'b0, to_cnt}, m_to);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1; cmd_adr = $urandom; cmd_we = $urandom;
            ack = 1'b1; sdat = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_dat", rsp_dat, exp_dat);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
            chk("hold_rdy", {31'b0, cmd_ready}, 32'd0);
            chk("hold_cyc", {31'b0, cyc}, 32'd0);
            chk("hold_adr", adr, t_adr);
        end
        cmd_valid = 1'b0; ack = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("ready_back", {31'b0, cmd_ready}, 32'd1);
        chk("cyc_idle", {31'b0, cyc}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_outs", {27'b0, rsp_valid, rsp_err, cyc, stb, we}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_to", {30'b0, to_cnt}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, 0);       // read, 2 stb cycles
        txn(1'b1, 32'h3000_0000, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 0, 0); // zero-wait write
        txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h5555_AAAA, TO, 0);      // no ack -> timeout
        txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_F00D, TO - 1, 0);  // ack on last cycle
        txn(1'b1, 32'h3000_0010, 32'hA5A5_5A5A, 4'b1100, 32'h0, 2, 5);    // backpressure

        for (int k = 0; k < 40; k++)
            txn($urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, TO + 1), $urandom_range(0, 3));

        // Reset in the middle of a bus cycle
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_stb_up", {31'b0, stb}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cycstb", {30'b0, cyc, stb}, 32'd0);
        chk("t5_ready", {31'b0, cmd_ready}, 32'd1);
        chk("t5_to", {30'b0, to_cnt}, 32'd0);
        m_to = 0;
        ack = 1'b1; sdat = 32'h1111_2222;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_stray", {29'b0, cmd_ready, cyc, rsp_valid}, 32'd4);
        ack = 1'b0;

        // Counter saturation
        for (int k = 0; k < 5; k++)
            txn($urandom, $urandom, $urandom, $urandom, $urandom, TO + 1, 0);
        chk("t6_sat", {30'b0, to_cnt}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
